// File: rtl/trx_seq_pkg.sv
// Shared encodings, widths and small helpers for the receive/transmit sequencer.
package trx_seq_pkg;
  localparam int CNT_W         = 16;
  localparam int ALC_DECAY_DIV = 1024;

  localparam logic [2:0] ST_RX        = 3'd0;
  localparam logic [2:0] ST_RELAY_ON  = 3'd1;
  localparam logic [2:0] ST_RAMP_UP   = 3'd2;
  localparam logic [2:0] ST_TX        = 3'd3;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd4;
  localparam logic [2:0] ST_HANG      = 3'd5;
  localparam logic [2:0] ST_RELAY_OFF = 3'd6;

  typedef enum logic [2:0] {
    S_RX        = ST_RX,
    S_RELAY_ON  = ST_RELAY_ON,
    S_RAMP_UP   = ST_RAMP_UP,
    S_TX        = ST_TX,
    S_RAMP_DOWN = ST_RAMP_DOWN,
    S_HANG      = ST_HANG,
    S_RELAY_OFF = ST_RELAY_OFF
  } seq_state_t;

  // Terminal count for an n-cycle wait; n=0 behaves like n=1.
  function automatic logic [CNT_W-1:0] last_count(input int n);
    return (n > 0) ? CNT_W'(n - 1) : '0;
  endfunction

  // One unit step toward the target; cur<tgt implies cur<255, so no wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) return cur + 8'd1;
    if (cur > tgt) return cur - 8'd1;
    return cur;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability filter for the raw CW key.
// Latency 2 + DEBOUNCE cycles from pin edge to key_db; no backpressure.
module key_debounce
  import trx_seq_pkg::*;
#(
  parameter int DEBOUNCE = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_db
);
  localparam logic [CNT_W-1:0] DB_LAST = last_count(DEBOUNCE);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      key_db <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      // Any return to the accepted level restarts the stability window.
      if (sync2 == key_db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        key_db <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/trx_sequencer.sv
// T/R sequencer: relay settle, ramped drive, hang and relay release; optional ALC via TRX_SEQ_ALC_EN.
// Request to relay in 1 cycle, outputs registered from the next state; no backpressure.
module trx_sequencer
  import trx_seq_pkg::*;
#(
  parameter int DEBOUNCE     = 50,
  parameter int RELAY_SETTLE = 500,
  parameter int RAMP_DIV     = 4,
  parameter int HANG_TIME    = 2000
) (
  input  logic       clock_100k,
  input  logic       reset,
  input  logic       cw_key,
  input  logic       ptt_req,
  input  logic [7:0] tx_level_in,
  input  logic       dac_of,
  output logic       relay,
  output logic       rx_mute,
  output logic       tx_enable,
  output logic [7:0] tx_level_out,
  output logic [2:0] state
);
  localparam logic [CNT_W-1:0] SETTLE_LAST = last_count(RELAY_SETTLE);
  localparam logic [CNT_W-1:0] DIV_LAST    = last_count(RAMP_DIV);
  localparam logic [CNT_W-1:0] HANG_LAST   = last_count(HANG_TIME);

  logic             key_db;
  logic             req;
  logic [7:0]       target;
  logic [7:0]       up_level;
  logic [7:0]       dn_level;
  logic             step_due;
  seq_state_t       st;
  seq_state_t       nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] div_n;
  logic [7:0]       level_n;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key (
    .clk     (clock_100k),
    .rst     (reset),
    .key_raw (cw_key),
    .key_db  (key_db)
  );

  assign req      = key_db | ptt_req;
  assign step_due = (div == DIV_LAST);
  assign up_level = step_toward(tx_level_out, target);
  assign dn_level = (tx_level_out == 8'd0) ? 8'd0 : tx_level_out - 8'd1;
  assign state    = st;

`ifdef TRX_SEQ_ALC_EN
  localparam int DECAY_W = $clog2(ALC_DECAY_DIV);

  logic [7:0]         atten;
  logic [DECAY_W-1:0] decay;
  logic               alc_win;

  assign alc_win = (st == S_TX) || (st == S_RAMP_UP);
  assign target  = (tx_level_in > atten) ? tx_level_in - atten : 8'd0;

  // Overflow pushes attenuation up at once; recovery is one step per decay period.
  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      atten <= '0;
      decay <= '0;
    end else if (nxt == S_RX && st != S_RX) begin
      atten <= '0;
      decay <= '0;
    end else if (alc_win && dac_of) begin
      if (atten < tx_level_in) atten <= atten + 8'd1;
      decay <= '0;
    end else begin
      decay <= decay + 1'b1;
      if (decay == DECAY_W'(ALC_DECAY_DIV - 1) && atten != 8'd0) atten <= atten - 8'd1;
    end
  end
`else
  logic unused_dac_of;
  assign unused_dac_of = dac_of;
  assign target        = tx_level_in;
`endif

  always_comb begin
    nxt     = st;
    cnt_n   = cnt + 1'b1;
    div_n   = step_due ? '0 : div + 1'b1;
    level_n = tx_level_out;
    case (st)
      S_RX: begin
        cnt_n   = '0;
        level_n = '0;
        if (req) nxt = S_RELAY_ON;
      end
      S_RELAY_ON: begin
        if (!req) begin
          nxt   = S_RELAY_OFF;
          cnt_n = '0;
        end else if (cnt == SETTLE_LAST) begin
          nxt   = S_RAMP_UP;
          div_n = '0;
        end
      end
      S_RAMP_UP: begin
        if (!req) begin
          nxt   = S_RAMP_DOWN;
          div_n = '0;
        end else if (tx_level_out == target) begin
          nxt = S_TX;
        end else if (step_due) begin
          level_n = up_level;
          if (up_level == target) nxt = S_TX;
        end
      end
      S_TX: begin
        level_n = target;
        if (!req) begin
          nxt   = S_RAMP_DOWN;
          div_n = '0;
        end
      end
      S_RAMP_DOWN: begin
        if (req) begin
          nxt   = S_RAMP_UP;
          div_n = '0;
        end else if (tx_level_out == 8'd0) begin
          nxt   = S_HANG;
          cnt_n = '0;
        end else if (step_due) begin
          level_n = dn_level;
          if (dn_level == 8'd0) begin
            nxt   = S_HANG;
            cnt_n = '0;
          end
        end
      end
      S_HANG: begin
        if (req) begin
          nxt   = S_RAMP_UP;
          div_n = '0;
        end else if (cnt == HANG_LAST) begin
          nxt   = S_RELAY_OFF;
          cnt_n = '0;
        end
      end
      // Relay release always completes so the contacts never switch mid-settle.
      S_RELAY_OFF: begin
        if (cnt == SETTLE_LAST) nxt = S_RX;
      end
      default: nxt = S_RX;
    endcase
  end

  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      st           <= S_RX;
      cnt          <= '0;
      div          <= '0;
      tx_level_out <= '0;
      relay        <= 1'b0;
      rx_mute      <= 1'b0;
      tx_enable    <= 1'b0;
    end else begin
      st           <= nxt;
      cnt          <= cnt_n;
      div          <= div_n;
      tx_level_out <= level_n;
      relay        <= nxt inside {S_RELAY_ON, S_RAMP_UP, S_TX, S_RAMP_DOWN, S_HANG};
      rx_mute      <= (nxt != S_RX);
      tx_enable    <= nxt inside {S_RAMP_UP, S_TX, S_RAMP_DOWN};
    end
  end
endmodule

// File: tb/tb_trx_sequencer.sv
// Scoreboard bench for trx_sequencer: expectations are queued with a due cycle and
// compared on the falling edge when that cycle arrives.
module tb_trx_sequencer;
  localparam int K_ST   = 0;
  localparam int K_RLY  = 1;
  localparam int K_MUTE = 2;
  localparam int K_EN   = 3;
  localparam int K_LVL  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cw_key = 1'b0;
  logic       ptt_req = 1'b0;
  logic       dac_of = 1'b0;
  logic [7:0] tx_level_in = 8'd0;
  logic       relay;
  logic       rx_mute;
  logic       tx_enable;
  logic [7:0] tx_level_out;
  logic [2:0] state;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string tag;
  } exp_t;
  exp_t sb[$];

  trx_sequencer #(
    .DEBOUNCE(4), .RELAY_SETTLE(10), .RAMP_DIV(1), .HANG_TIME(20)
  ) dut (
    .clock_100k   (clk),
    .reset        (rst),
    .cw_key       (cw_key),
    .ptt_req      (ptt_req),
    .tx_level_in  (tx_level_in),
    .dac_of       (dac_of),
    .relay        (relay),
    .rx_mute      (rx_mute),
    .tx_enable    (tx_enable),
    .tx_level_out (tx_level_out),
    .state        (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs != exp_v) begin
      n_miss++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int observe(input int kind);
    case (kind)
      K_ST:    return int'(state);
      K_RLY:   return int'(relay);
      K_MUTE:  return int'(rx_mute);
      K_EN:    return int'(tx_enable);
      K_LVL:   return int'(tx_level_out);
      default: return -1;
    endcase
  endfunction

  task automatic push(input int at, input int kind, input int val, input string tag);
    exp_t e;
    e.cyc  = at;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  task automatic wait_state(input int s, input int bound, input string tag);
    int n = 0;
    while (int'(state) != s && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, int'(state), s);
  endtask

  // Scoreboard consumer: compare every entry whose due cycle is now.
  initial begin
    int i;
    forever begin
      @(negedge clk);
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].cyc == cyc) begin
          chk(sb[i].tag, observe(sb[i].kind), sb[i].val);
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          chk({sb[i].tag, "_late"}, cyc, sb[i].cyc);
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish by 400000");
    $fatal(1, "bench timeout");
  end

  initial begin
    int b;
    int d;
    int g;
    int h;
    int a;
    int e;
    int t;

    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_relay", int'(relay), 0);
    chk("rst_mute", int'(rx_mute), 0);
    chk("rst_en", int'(tx_enable), 0);
    chk("rst_lvl", int'(tx_level_out), 0);
    rst = 1'b0;

    // Full PTT cycle at level 8.
    @(negedge clk);
    tx_level_in = 8'd8;
    ptt_req = 1'b1;
    b = cyc;
    push(b + 1, K_ST, 1, "ptt_relay_on");
    push(b + 1, K_RLY, 1, "ptt_relay");
    push(b + 1, K_MUTE, 1, "ptt_mute");
    push(b + 10, K_EN, 0, "ptt_en_early");
    push(b + 11, K_EN, 1, "ptt_en");
    push(b + 11, K_ST, 2, "ptt_ramp_up");
    push(b + 12, K_LVL, 1, "ptt_lvl1");
    push(b + 18, K_LVL, 7, "ptt_lvl7");
    push(b + 19, K_LVL, 8, "ptt_lvl8");
    push(b + 19, K_ST, 3, "ptt_tx");
    drain("ptt_up");

    @(negedge clk);
    ptt_req = 1'b0;
    d = cyc;
    push(d + 1, K_ST, 4, "drop_ramp_down");
    push(d + 1, K_LVL, 8, "drop_lvl8");
    push(d + 8, K_LVL, 1, "drop_lvl1");
    push(d + 9, K_LVL, 0, "drop_lvl0");
    push(d + 9, K_ST, 5, "drop_hang");
    push(d + 9, K_EN, 0, "drop_en_off");
    push(d + 28, K_RLY, 1, "hang_relay_held");
    push(d + 29, K_RLY, 0, "relay_off");
    push(d + 29, K_ST, 6, "relay_off_st");
    push(d + 38, K_MUTE, 1, "mute_held");
    push(d + 39, K_MUTE, 0, "mute_clear");
    push(d + 39, K_ST, 0, "back_rx");
    drain("ptt_down");

    // CW glitch of 3 cycles must be filtered.
    @(negedge clk);
    cw_key = 1'b1;
    g = cyc;
    for (int k = 1; k <= 12; k++) push(g + k, K_ST, 0, "cw_glitch_rx");
    repeat (3) @(negedge clk);
    cw_key = 1'b0;
    drain("cw_glitch");

    // CW held: RELAY_ON 7 cycles after the edge.
    @(negedge clk);
    cw_key = 1'b1;
    h = cyc;
    push(h + 6, K_ST, 0, "cw_pre");
    push(h + 7, K_ST, 1, "cw_relay_on");
    push(h + 7, K_RLY, 1, "cw_relay");
    push(h + 8, K_EN, 0, "cw_en_off");
    repeat (10) @(negedge clk);
    cw_key = 1'b0;
    drain("cw_hold");
    wait_state(0, 100, "cw_back_rx");

    // Abort in RELAY_ON at settle count 5.
    @(negedge clk);
    ptt_req = 1'b1;
    a = cyc;
    for (int k = 1; k <= 17; k++) push(a + k, K_EN, 0, "abort_en_low");
    push(a + 6, K_ST, 1, "abort_relay_on");
    push(a + 7, K_ST, 6, "abort_relay_off");
    push(a + 7, K_RLY, 0, "abort_relay");
    push(a + 7, K_MUTE, 1, "abort_mute");
    push(a + 16, K_ST, 6, "abort_held");
    push(a + 17, K_ST, 0, "abort_rx");
    push(a + 17, K_MUTE, 0, "abort_unmute");
    repeat (6) @(negedge clk);
    ptt_req = 1'b0;
    drain("abort");

    // Re-key during RAMP_DOWN at level 5.
    @(negedge clk);
    ptt_req = 1'b1;
    wait_state(3, 60, "rekey_tx");
    repeat (3) @(negedge clk);
    ptt_req = 1'b0;
    d = cyc;
    for (int k = 1; k <= 8; k++) push(d + k, K_RLY, 1, "rekey_relay_held");
    push(d + 1, K_ST, 4, "rekey_ramp_down");
    push(d + 4, K_LVL, 5, "rekey_lvl5");
    repeat (4) @(negedge clk);
    ptt_req = 1'b1;
    push(d + 5, K_ST, 2, "rekey_ramp_up");
    push(d + 5, K_LVL, 5, "rekey_resume5");
    push(d + 6, K_LVL, 6, "rekey_lvl6");
    push(d + 8, K_ST, 3, "rekey_tx_again");
    push(d + 8, K_LVL, 8, "rekey_lvl8");
    drain("rekey_down");

    // Re-key during HANG ramps up from 0.
    @(negedge clk);
    ptt_req = 1'b0;
    e = cyc;
    for (int k = 1; k <= 21; k++) push(e + k, K_RLY, 1, "hang_relay_held");
    push(e + 9, K_ST, 5, "hang_st");
    push(e + 9, K_LVL, 0, "hang_lvl0");
    repeat (12) @(negedge clk);
    ptt_req = 1'b1;
    push(e + 13, K_ST, 2, "hang_ramp_up");
    push(e + 13, K_LVL, 0, "hang_from0");
    push(e + 14, K_LVL, 1, "hang_lvl1");
    push(e + 21, K_ST, 3, "hang_tx");
    push(e + 21, K_LVL, 8, "hang_lvl8");
    drain("rekey_hang");

    // Target change in TX tracks one cycle later.
    @(negedge clk);
    tx_level_in = 8'd200;
    t = cyc;
    push(t + 1, K_LVL, 200, "tx_track_200");
    push(t + 1, K_ST, 3, "tx_track_st");
    drain("tx_track");

    // Asynchronous reset mid-TX.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_relay", int'(relay), 0);
    chk("arst_mute", int'(rx_mute), 0);
    chk("arst_en", int'(tx_enable), 0);
    chk("arst_lvl", int'(tx_level_out), 0);
    ptt_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

`ifdef TRX_SEQ_ALC_EN
    @(negedge clk);
    tx_level_in = 8'd100;
    ptt_req = 1'b1;
    wait_state(3, 300, "alc_tx");
    @(negedge clk);
    dac_of = 1'b1;
    t = cyc;
    repeat (3) @(negedge clk);
    dac_of = 1'b0;
    push(t + 4, K_LVL, 97, "alc_lvl97");
    push(t + 1027, K_LVL, 97, "alc_hold97");
    push(t + 1028, K_LVL, 98, "alc_decay98");
    drain("alc");
    ptt_req = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
